enemy_datapath: RTL and testbench
=================================

# enemy_datapath

Datapath partner of the enemy controller FSM. It holds one enemy's X/Y position and generates the frame-rate timing pulse (`updatePosition`) that the controller waits on. It also reports the two events that return the controller to its reset state: `bottomReached` and `collidedWithBullet`. It consumes the controller's state flags (`inResetState`, `inUpdatePositionStateE`) and feeds its position to the renderer and the bullet logic.

## Interface
Parameters:
- `CLKS_PER_FRAME`, default 833333: clock cycles per 1/60 s frame at 50 MHz.
- `FRAMES_PER_STEP`, default 4: frames between position steps.
- `SCREEN_W`, default 160: screen width in pixels.
- `SCREEN_H`, default 120: screen height in pixels.
- `BOX`, default 4: enemy square edge in pixels.
- `STEP_Y`, default 1: pixels moved down per step.
- `SPAWN_Y`, default 0: Y on spawn.
- `LFSR_SEED`, default 8'hA5: LFSR reset value; must be non-zero.

Ports:
- `clk` in 1: system clock.
- `resetn` in 1: reset, asynchronous, active-low.
- `inResetState` in 1: controller is in its reset/spawn state.
- `inUpdatePositionStateE` in 1: controller is in its update-position state (one-cycle pulse).
- `bulletValid` in 1: bullet coordinates are valid this cycle.
- `bulletX` in 8: bullet pixel X.
- `bulletY` in 7: bullet pixel Y.
- `enemyX` out 8: top-left X of the enemy box.
- `enemyY` out 7: top-left Y of the enemy box.
- `updatePosition` out 1: one-cycle step request to the controller.
- `bottomReached` out 1: enemy is at the lowest legal Y.
- `collidedWithBullet` out 1: sticky hit flag.

## Operation
- **Delay counter.**
  - Counts down from CLKS_PER_FRAME-1 to 0.
  - At 0 it produces an internal `frameTick` for one cycle and reloads CLKS_PER_FRAME-1.
  - Held at CLKS_PER_FRAME-1 while `inResetState`=1.
- **Frame counter.**
  - Range 0..FRAMES_PER_STEP-1; increments on `frameTick`.
  - On `frameTick` with count = FRAMES_PER_STEP-1, it wraps to 0 and `updatePosition` is registered high for exactly one cycle.
  - Held at 0 while `inResetState`=1.
- **LFSR.**
  - 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1, advances every clock.
  - Never reaches zero.
- **Spawn** (`inResetState`=1, every cycle):
  - R = SCREEN_W-BOX+1.
  - `enemyX` <= lfsr if lfsr < R, else lfsr-R; the result is always in 0..SCREEN_W-BOX.
  - `enemyY` <= SPAWN_Y.
- **Step** (`inUpdatePositionStateE`=1): `enemyY` <= min(`enemyY`+STEP_Y, SCREEN_H-BOX). The sum is computed 8 bits wide so it cannot wrap. `enemyX` is unchanged.
- **If both state flags are high**, spawn wins.
- **`bottomReached`** is combinational: (`enemyY` >= SCREEN_H-BOX).
- **Collision.**
  - Hit = `bulletValid` && `enemyX` <= `bulletX` <= `enemyX`+BOX-1 && `enemyY` <= `bulletY` <= `enemyY`+BOX-1.
  - Bounds are computed 9 bits wide.
  - A hit sets the sticky `collidedWithBullet` register.
  - `inResetState`=1 clears the register. A clear and a hit in the same cycle leave it at 0.
- **Reset** (`resetn`=0, asynchronous, at any time including mid-step):
  - `enemyX`=0, `enemyY`=SPAWN_Y.
  - Delay counter = CLKS_PER_FRAME-1, frame counter = 0.
  - `updatePosition`=0, `collidedWithBullet`=0, LFSR = LFSR_SEED.
  - `bottomReached` follows Y and is therefore 0 with default parameters.

## Timing
- All state changes happen on the rising edge of `clk`; only `bottomReached` is combinational.
- `updatePosition` period = CLKS_PER_FRAME × FRAMES_PER_STEP cycles, measured from the cycle `inResetState` falls.
  - First pulse: CLKS_PER_FRAME×FRAMES_PER_STEP cycles after `inResetState` deasserts.
- Step latency: `enemyY` takes its new value on the edge that ends the `inUpdatePositionStateE` cycle.
  - During that cycle the controller samples `bottomReached` for the pre-step Y.
  - The bottom is therefore reported on the step after Y saturates.
- Collision latency: `collidedWithBullet` rises one edge after the overlapping bullet cycle and stays high until `inResetState`.

## Test plan
Parameters for the bench: CLKS_PER_FRAME=4, FRAMES_PER_STEP=2, defaults otherwise.
1. **Reset mid-operation:** assert `resetn`=0 while Y=50 and the flag is set → `enemyX`=0, `enemyY`=0, `collidedWithBullet`=0, `updatePosition`=0 in the same cycle, without waiting for a clock edge.
2. **Frame timing:** `inResetState`=1 for 3 cycles, then 0 → `updatePosition` pulses for one cycle at cycle 8 after the release, then every 8 cycles; it is never high for two consecutive cycles.
3. **Spawn range:** 300 consecutive spawn cycles → every `enemyX` is in 0..156 and `enemyY`=0. The LFSR sequence has period 255 and never shows 0.
4. **Step and saturation:** start at Y=114 and give 4 update pulses → Y = 115, 116, 116, 116. `bottomReached`=1 from Y=116 onward; the pulse with pre-step Y=116 sees `bottomReached`=1.
5. **Collision edges:** enemy at (10,20).
   - Bullets at (10,20) and (13,23) each set the flag.
   - Bullets at (14,20), (9,20) and (10,24) do not.
   - A hit with `bulletValid`=0 does not set the flag.
6. **Collision priority:** flag set, then a hit coincides with `inResetState`=1 → flag is 0 after the edge. On the next hit after release the flag is 1.

Source files
------------

// File: rtl/enemy_datapath.sv
// Position, frame timing, spawn randomisation and bullet-hit detection for one enemy.
// Works alongside the enemy controller FSM, which supplies the state flags.
module enemy_datapath #(
   parameter int         CLKS_PER_FRAME  = 833333,
   parameter int         FRAMES_PER_STEP = 4,
   parameter int         SCREEN_W        = 160,
   parameter int         SCREEN_H        = 120,
   parameter int         BOX             = 4,
   parameter int         STEP_Y          = 1,
   parameter int         SPAWN_Y         = 0,
   parameter logic [7:0] LFSR_SEED       = 8'hA5
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       inResetState,
   input  logic       inUpdatePositionStateE,
   input  logic       bulletValid,
   input  logic [7:0] bulletX,
   input  logic [6:0] bulletY,
   output logic [7:0] enemyX,
   output logic [6:0] enemyY,
   output logic       updatePosition,
   output logic       bottomReached,
   output logic       collidedWithBullet
);

   localparam int DW = (CLKS_PER_FRAME > 1) ? $clog2(CLKS_PER_FRAME) : 1;
   localparam int FW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

   localparam logic [DW-1:0] DELAY_MAX = DW'(CLKS_PER_FRAME - 1);
   localparam logic [FW-1:0] FRAME_MAX = FW'(FRAMES_PER_STEP - 1);
   localparam logic [7:0]    SPAN      = 8'(SCREEN_W - BOX + 1);
   localparam logic [6:0]    Y_MAX     = 7'(SCREEN_H - BOX);
   localparam logic [6:0]    Y_SPAWN   = 7'(SPAWN_Y);
   localparam logic [7:0]    Y_STEP    = 8'(STEP_Y);
   localparam logic [8:0]    BOX_EXT   = 9'(BOX - 1);

   logic [DW-1:0] delay_cnt;
   logic [FW-1:0] frame_cnt;
   logic          frame_tick;
   logic [7:0]    lfsr;
   logic          lfsr_fb;
   logic [7:0]    spawn_x;
   logic [7:0]    y_sum;
   logic [6:0]    y_next;
   logic [8:0]    x_lo;
   logic [8:0]    x_hi;
   logic [8:0]    y_lo;
   logic [8:0]    y_hi;
   logic [8:0]    bx_ext;
   logic [8:0]    by_ext;
   logic          hit;

   assign frame_tick = !inResetState && (delay_cnt == '0);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         delay_cnt <= DELAY_MAX;
      end else if (inResetState || frame_tick) begin
         delay_cnt <= DELAY_MAX;
      end else begin
         delay_cnt <= delay_cnt - DW'(1);
      end
   end

   // The step request is registered, so it appears the cycle after the last frame tick.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         frame_cnt      <= '0;
         updatePosition <= 1'b0;
      end else begin
         updatePosition <= frame_tick && (frame_cnt == FRAME_MAX);
         if (inResetState) begin
            frame_cnt <= '0;
         end else if (frame_tick) begin
            frame_cnt <= (frame_cnt == FRAME_MAX) ? '0 : frame_cnt + FW'(1);
         end
      end
   end

   // x^8+x^6+x^5+x^4+1, maximal length so a non-zero seed never reaches zero.
   assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         lfsr <= LFSR_SEED;
      end else begin
         lfsr <= {lfsr[6:0], lfsr_fb};
      end
   end

   assign spawn_x = (lfsr < SPAN) ? lfsr : lfsr - SPAN;
   assign y_sum   = {1'b0, enemyY} + Y_STEP;
   assign y_next  = (y_sum >= {1'b0, Y_MAX}) ? Y_MAX : y_sum[6:0];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         enemyX <= 8'd0;
         enemyY <= Y_SPAWN;
      end else if (inResetState) begin
         enemyX <= spawn_x;
         enemyY <= Y_SPAWN;
      end else if (inUpdatePositionStateE) begin
         enemyY <= y_next;
      end
   end

   assign bottomReached = (enemyY >= Y_MAX);

   // Box bounds are one bit wider than X so the right edge cannot wrap.
   assign x_lo   = {1'b0, enemyX};
   assign x_hi   = {1'b0, enemyX} + BOX_EXT;
   assign y_lo   = {2'b00, enemyY};
   assign y_hi   = {2'b00, enemyY} + BOX_EXT;
   assign bx_ext = {1'b0, bulletX};
   assign by_ext = {2'b00, bulletY};
   assign hit    = bulletValid && (bx_ext >= x_lo) && (bx_ext <= x_hi)
                   && (by_ext >= y_lo) && (by_ext <= y_hi);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         collidedWithBullet <= 1'b0;
      end else if (inResetState) begin
         collidedWithBullet <= 1'b0;
      end else if (hit) begin
         collidedWithBullet <= 1'b1;
      end
   end

endmodule

// File: tb/tb_enemy_datapath.sv
// Directed bench for enemy_datapath with a short frame (4 clocks) and 2 frames per step.
module tb_enemy_datapath;

   logic       clk = 1'b0;
   logic       resetn;
   logic       inResetState;
   logic       inUpdatePositionStateE;
   logic       bulletValid;
   logic [7:0] bulletX;
   logic [6:0] bulletY;
   logic [7:0] enemyX;
   logic [6:0] enemyY;
   logic       updatePosition;
   logic       bottomReached;
   logic       collidedWithBullet;

   int total = 0;
   int bad   = 0;

   logic [7:0] m_lfsr;
   logic [7:0] exp_x;
   logic [7:0] x_hist [0:299];

   enemy_datapath #(
      .CLKS_PER_FRAME (4),
      .FRAMES_PER_STEP(2)
   ) dut (
      .clk                   (clk),
      .resetn                (resetn),
      .inResetState          (inResetState),
      .inUpdatePositionStateE(inUpdatePositionStateE),
      .bulletValid           (bulletValid),
      .bulletX               (bulletX),
      .bulletY               (bulletY),
      .enemyX                (enemyX),
      .enemyY                (enemyY),
      .updatePosition        (updatePosition),
      .bottomReached         (bottomReached),
      .collidedWithBullet    (collidedWithBullet)
   );

   always #5 clk = ~clk;

   // Reference LFSR: predicts the value the DUT uses for the next spawn.
   always @(posedge clk or negedge resetn) begin
      if (!resetn) m_lfsr <= 8'hA5;
      else         m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
   end

   function automatic logic [7:0] spawnX(input logic [7:0] l);
      return (l < 8'd157) ? l : l - 8'd157;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input int pulses);
      for (int i = 0; i < pulses; i++) begin
         inUpdatePositionStateE = 1'b1;
         tick();
         inUpdatePositionStateE = 1'b0;
         tick();
      end
   endtask

   // Spawns until the predicted X matches, then steps down to the requested Y.
   task automatic placeEnemy(input logic [7:0] x, input int y);
      bit found = 0;
      inResetState = 1'b1;
      for (int i = 0; i < 300 && !found; i++) begin
         if (spawnX(m_lfsr) == x) found = 1;
         tick();
      end
      inResetState = 1'b0;
      checkOutput("place_found", 32'(found), 32'd1);
      applyStimulus(y);
      checkOutput("place_x", 32'(enemyX), 32'(x));
      checkOutput("place_y", 32'(enemyY), 32'(y));
   endtask

   task automatic shootAt(input string tag, input logic [7:0] bx, input logic [6:0] by,
                          input logic valid, input logic expect_flag);
      bulletX     = bx;
      bulletY     = by;
      bulletValid = valid;
      tick();
      bulletValid = 1'b0;
      checkOutput(tag, 32'(collidedWithBullet), 32'(expect_flag));
   endtask

   initial begin
      resetn                 = 1'b0;
      inResetState           = 1'b0;
      inUpdatePositionStateE = 1'b0;
      bulletValid            = 1'b0;
      bulletX                = 8'd0;
      bulletY                = 7'd0;
      #12;
      checkOutput("rst_x", 32'(enemyX), 32'd0);
      checkOutput("rst_y", 32'(enemyY), 32'd0);
      checkOutput("rst_upd", 32'(updatePosition), 32'd0);
      checkOutput("rst_hit", 32'(collidedWithBullet), 32'd0);
      checkOutput("rst_bottom", 32'(bottomReached), 32'd0);
      resetn = 1'b1;
      tick();

      // Reset mid-operation, observed before any clock edge
      placeEnemy(8'd10, 50);
      shootAt("mid_hit", 8'd11, 7'd51, 1'b1, 1'b1);
      @(posedge clk);
      #2;
      resetn = 1'b0;
      #1;
      checkOutput("async_x", 32'(enemyX), 32'd0);
      checkOutput("async_y", 32'(enemyY), 32'd0);
      checkOutput("async_hit", 32'(collidedWithBullet), 32'd0);
      checkOutput("async_upd", 32'(updatePosition), 32'd0);
      #5;
      resetn = 1'b1;
      tick();

      // Frame timing: pulse at cycles 8, 16, 24 after release
      inResetState = 1'b1;
      tick(); tick(); tick();
      inResetState = 1'b0;
      for (int k = 0; k < 26; k++) begin
         @(negedge clk);
         checkOutput($sformatf("upd_c%0d", k), 32'(updatePosition),
                     32'((k == 8) || (k == 16) || (k == 24)));
         tick();
      end

      // Spawn range and sequence over 300 cycles
      inResetState = 1'b1;
      for (int i = 0; i < 300; i++) begin
         exp_x = spawnX(m_lfsr);
         tick();
         x_hist[i] = enemyX;
         checkOutput($sformatf("spawn_x%0d", i), 32'(enemyX), 32'(exp_x));
         checkOutput($sformatf("spawn_rng%0d", i), 32'(enemyX <= 8'd156), 32'd1);
         checkOutput($sformatf("spawn_y%0d", i), 32'(enemyY), 32'd0);
         if (i >= 255)
            checkOutput($sformatf("period%0d", i), 32'(x_hist[i]), 32'(x_hist[i-255]));
      end
      inResetState = 1'b0;

      // Step and saturation from Y=114
      placeEnemy(8'd10, 114);
      begin
         logic [6:0] exp_y [0:3];
         logic       exp_b [0:3];
         exp_y = '{7'd115, 7'd116, 7'd116, 7'd116};
         exp_b = '{1'b0, 1'b0, 1'b1, 1'b1};
         for (int i = 0; i < 4; i++) begin
            inUpdatePositionStateE = 1'b1;
            checkOutput($sformatf("pre_bottom%0d", i), 32'(bottomReached), 32'(exp_b[i]));
            tick();
            inUpdatePositionStateE = 1'b0;
            checkOutput($sformatf("step_y%0d", i), 32'(enemyY), 32'(exp_y[i]));
            checkOutput($sformatf("post_bottom%0d", i), 32'(bottomReached), 32'(exp_y[i] >= 7'd116));
            tick();
         end
      end

      // Collision edges with enemy at (10,20)
      placeEnemy(8'd10, 20);
      shootAt("miss_right", 8'd14, 7'd20, 1'b1, 1'b0);
      shootAt("miss_left", 8'd9, 7'd20, 1'b1, 1'b0);
      shootAt("miss_below", 8'd10, 7'd24, 1'b1, 1'b0);
      shootAt("miss_invalid", 8'd10, 7'd20, 1'b0, 1'b0);
      shootAt("hit_topleft", 8'd10, 7'd20, 1'b1, 1'b1);
      tick();
      checkOutput("hit_sticky", 32'(collidedWithBullet), 32'd1);
      placeEnemy(8'd10, 20);
      checkOutput("cleared", 32'(collidedWithBullet), 32'd0);
      shootAt("hit_botright", 8'd13, 7'd23, 1'b1, 1'b1);

      // Clear beats a simultaneous hit
      exp_x        = spawnX(m_lfsr);
      inResetState = 1'b1;
      bulletX      = 8'd12;
      bulletY      = 7'd21;
      bulletValid  = 1'b1;
      tick();
      inResetState = 1'b0;
      bulletValid  = 1'b0;
      checkOutput("prio_clear", 32'(collidedWithBullet), 32'd0);
      checkOutput("prio_x", 32'(enemyX), 32'(exp_x));
      shootAt("hit_after_release", exp_x, 7'd0, 1'b1, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
